// File: rtl/frame_buf_sched.sv
// Triple-buffer frame scheduler: rotates three DDR frame regions between camera writer and display reader.
// Optional macro FRAME_STAT_EN adds saturating drop/repeat status counters.
module frame_buf_sched #(
    parameter logic [29:0] FRAME_BYTES = 30'd614400,
    parameter logic [29:0] BASE_ADDR   = 30'd0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        init_done,
    input  logic        wr_vsync,
    input  logic        rd_vsync,
    output logic [29:0] wr_b_addr,
    output logic [29:0] wr_e_addr,
    output logic [29:0] rd_b_addr,
    output logic [29:0] rd_e_addr,
    output logic        wr_rst,
    output logic        rd_rst,
    output logic        frame_valid
`ifdef FRAME_STAT_EN
    ,
    output logic [15:0] drop_cnt,
    output logic [15:0] repeat_cnt
`endif
);

    typedef enum logic [1:0] {ST_INIT, ST_PRIME1, ST_PRIME2, ST_RUN} state_t;

    localparam logic [29:0] OFF_1 = FRAME_BYTES;
    localparam logic [29:0] OFF_2 = FRAME_BYTES + FRAME_BYTES;

    state_t      r_state, w_next_state;
    logic [2:0]  r_wr_sync, r_rd_sync;
    logic        r_wr_ev, r_rd_ev;
    logic [1:0]  r_w, r_f, r_r;
    logic        r_rdy;
    logic        r_wr_pend, r_rd_pend, r_fv_set;
    logic        w_reload, w_wr_swap, w_rd_swap, w_wr_pulse, w_rd_pulse;

    function automatic logic [29:0] region_base(input logic [1:0] bank);
        case (bank)
            2'd1:    return BASE_ADDR + OFF_1;
            2'd2:    return BASE_ADDR + OFF_2;
            default: return BASE_ADDR;
        endcase
    endfunction

    // NOTE: vsyncs are asynchronous, so nothing reads them before two flops; sequential state always uses <=.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_wr_sync <= '0;
            r_rd_sync <= '0;
            r_wr_ev   <= 1'b0;
            r_rd_ev   <= 1'b0;
        end else begin
            r_wr_sync <= {r_wr_sync[1:0], wr_vsync};
            r_rd_sync <= {r_rd_sync[1:0], rd_vsync};
            r_wr_ev   <= r_wr_sync[1] & ~r_wr_sync[2];
            r_rd_ev   <= r_rd_sync[1] & ~r_rd_sync[2];
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) r_state <= ST_INIT;
        else            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (!init_done) begin
            w_next_state = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT:   w_next_state = ST_PRIME1;
                ST_PRIME1: if (r_wr_ev) w_next_state = ST_PRIME2;
                ST_PRIME2: if (r_wr_ev) w_next_state = ST_RUN;
                default:   w_next_state = r_state;
            endcase
        end
    end

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        w_reload   = 1'b0;
        w_wr_swap  = 1'b0;
        w_rd_swap  = 1'b0;
        w_wr_pulse = 1'b0;
        w_rd_pulse = 1'b0;
        if (!init_done || r_state == ST_INIT) begin
            w_reload = 1'b1;
        end else begin
            case (r_state)
                ST_PRIME1: w_wr_pulse = r_wr_ev;
                ST_PRIME2: begin
                    w_wr_swap  = r_wr_ev;
                    w_wr_pulse = r_wr_ev;
                end
                ST_RUN: begin
                    w_wr_swap  = r_wr_ev;
                    w_wr_pulse = r_wr_ev;
                    w_rd_pulse = r_rd_ev;
                    // A same-cycle write makes F ready before the read looks at it.
                    w_rd_swap  = r_rd_ev & (r_rdy | r_wr_ev);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_w       <= 2'd0;
            r_f       <= 2'd1;
            r_r       <= 2'd2;
            r_rdy     <= 1'b0;
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_fv_set  <= 1'b0;
        end else if (w_reload) begin
            r_w       <= 2'd0;
            r_f       <= 2'd1;
            r_r       <= 2'd2;
            r_rdy     <= 1'b0;
            r_wr_pend <= 1'b0;
            r_rd_pend <= 1'b0;
            r_fv_set  <= 1'b0;
        end else begin
            r_wr_pend <= w_wr_pulse;
            r_rd_pend <= w_rd_pulse;
            r_fv_set  <= w_rd_swap;
            case ({w_wr_swap, w_rd_swap})
                2'b11: begin
                    r_r   <= r_w;
                    r_w   <= r_f;
                    r_f   <= r_r;
                    r_rdy <= 1'b0;
                end
                2'b10: begin
                    r_w   <= r_f;
                    r_f   <= r_w;
                    r_rdy <= 1'b1;
                end
                2'b01: begin
                    r_r   <= r_f;
                    r_f   <= r_r;
                    r_rdy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Addresses only move together with their restart pulse, one cycle after the bank update.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_b_addr   <= BASE_ADDR;
            wr_e_addr   <= BASE_ADDR + OFF_1;
            rd_b_addr   <= BASE_ADDR + OFF_2;
            rd_e_addr   <= BASE_ADDR + OFF_2 + OFF_1;
            wr_rst      <= 1'b0;
            rd_rst      <= 1'b0;
            frame_valid <= 1'b0;
        end else if (!init_done || r_state == ST_INIT) begin
            wr_b_addr   <= BASE_ADDR;
            wr_e_addr   <= BASE_ADDR + OFF_1;
            rd_b_addr   <= BASE_ADDR + OFF_2;
            rd_e_addr   <= BASE_ADDR + OFF_2 + OFF_1;
            wr_rst      <= 1'b0;
            rd_rst      <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            wr_rst <= r_wr_pend;
            rd_rst <= r_rd_pend;
            if (r_wr_pend) begin
                wr_b_addr <= region_base(r_w);
                wr_e_addr <= region_base(r_w) + FRAME_BYTES;
            end
            if (r_rd_pend) begin
                rd_b_addr <= region_base(r_r);
                rd_e_addr <= region_base(r_r) + FRAME_BYTES;
            end
            if (r_fv_set) frame_valid <= 1'b1;
        end
    end

`ifdef FRAME_STAT_EN
    logic w_drop, w_repeat;
    assign w_drop   = init_done && r_state == ST_RUN && r_wr_ev && !r_rd_ev && r_rdy;
    assign w_repeat = init_done && r_state == ST_RUN && r_rd_ev && !r_wr_ev && !r_rdy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            drop_cnt   <= 16'd0;
            repeat_cnt <= 16'd0;
        end else begin
            if (w_drop && drop_cnt != 16'hFFFF)     drop_cnt   <= drop_cnt + 16'd1;
            if (w_repeat && repeat_cnt != 16'hFFFF) repeat_cnt <= repeat_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_frame_buf_sched.sv
// Directed bench for frame_buf_sched: a bank model pushes expected pulse records, a monitor pops and compares them.
module tb_frame_buf_sched;

    localparam int FB = 614400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_done;
    logic        wr_vsync;
    logic        rd_vsync;
    logic [29:0] wr_b_addr, wr_e_addr, rd_b_addr, rd_e_addr;
    logic        wr_rst, rd_rst, frame_valid;
`ifdef FRAME_STAT_EN
    logic [15:0] drop_cnt, repeat_cnt;
`endif

    frame_buf_sched dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .init_done   (init_done),
        .wr_vsync    (wr_vsync),
        .rd_vsync    (rd_vsync),
        .wr_b_addr   (wr_b_addr),
        .wr_e_addr   (wr_e_addr),
        .rd_b_addr   (rd_b_addr),
        .rd_e_addr   (rd_e_addr),
        .wr_rst      (wr_rst),
        .rd_rst      (rd_rst),
        .frame_valid (frame_valid)
`ifdef FRAME_STAT_EN
        ,
        .drop_cnt    (drop_cnt),
        .repeat_cnt  (repeat_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic        wr_rst;
        logic        rd_rst;
        logic [29:0] wr_b, wr_e, rd_b, rd_e;
        logic        fv;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    int n_assert = 0;
    int n_fail   = 0;

    // Model state: 0 init, 1 prime1, 2 prime2, 3 run.
    int          m_state, m_w, m_f, m_r, m_drop, m_repeat;
    bit          m_rdy, m_fv;
    logic [29:0] m_wr_b, m_wr_e, m_rd_b, m_rd_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] region(input int bank);
        return 30'(bank * FB);
    endfunction

    task automatic model_reset();
        m_state = 0; m_w = 0; m_f = 1; m_r = 2; m_rdy = 0; m_fv = 0;
        m_wr_b = 30'd0;    m_wr_e = 30'(FB);
        m_rd_b = 30'(2*FB); m_rd_e = 30'(3*FB);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && (wr_rst === 1'b1 || rd_rst === 1'b1)) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({wr_rst, rd_rst}), 32'd0);
            end else begin
                e_mon = sb.pop_front();
                check("pulse_cycle", 32'(cyc), 32'(e_mon.cyc));
                check("wr_rst", 32'(wr_rst), 32'(e_mon.wr_rst));
                check("rd_rst", 32'(rd_rst), 32'(e_mon.rd_rst));
                check("wr_b_addr", 32'(wr_b_addr), 32'(e_mon.wr_b));
                check("wr_e_addr", 32'(wr_e_addr), 32'(e_mon.wr_e));
                check("rd_b_addr", 32'(rd_b_addr), 32'(e_mon.rd_b));
                check("rd_e_addr", 32'(rd_e_addr), 32'(e_mon.rd_e));
                check("frame_valid", 32'(frame_valid), 32'(e_mon.fv));
            end
        end
    end

    // One vsync pulse (3 cycles high); the model predicts the registered outputs 4 edges after the rising sample.
    task automatic step(input bit wr, input bit rd);
        bit   do_wr = 0, do_rd = 0, rdy0;
        int   tmp;
        exp_t e;
        @(negedge clk);
        rdy0 = m_rdy;
        case (m_state)
            1: if (wr) begin do_wr = 1; m_state = 2; end
            2: if (wr) begin
                tmp = m_w; m_w = m_f; m_f = tmp; m_rdy = 1; do_wr = 1; m_state = 3;
            end
            3: begin
                if (wr) begin
                    if (rdy0 && !rd) m_drop++;
                    tmp = m_w; m_w = m_f; m_f = tmp; m_rdy = 1; do_wr = 1;
                end
                if (rd) begin
                    if (!rdy0 && !wr) m_repeat++;
                    if (m_rdy) begin
                        tmp = m_r; m_r = m_f; m_f = tmp; m_rdy = 0; m_fv = 1;
                    end
                    do_rd = 1;
                end
            end
            default: ;
        endcase
        if (do_wr) begin m_wr_b = region(m_w); m_wr_e = region(m_w) + 30'(FB); end
        if (do_rd) begin m_rd_b = region(m_r); m_rd_e = region(m_r) + 30'(FB); end
        if (do_wr || do_rd) begin
            e.cyc = cyc + 5; e.wr_rst = do_wr; e.rd_rst = do_rd;
            e.wr_b = m_wr_b; e.wr_e = m_wr_e; e.rd_b = m_rd_b; e.rd_e = m_rd_e; e.fv = m_fv;
            sb.push_back(e);
        end
        wr_vsync = wr;
        rd_vsync = rd;
        repeat (3) @(negedge clk);
        wr_vsync = 1'b0;
        rd_vsync = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_b"}, 32'(wr_b_addr), 32'd0);
        check({tag, "_wr_e"}, 32'(wr_e_addr), 32'(FB));
        check({tag, "_rd_b"}, 32'(rd_b_addr), 32'(2*FB));
        check({tag, "_rd_e"}, 32'(rd_e_addr), 32'(3*FB));
        check({tag, "_rsts"}, 32'({wr_rst, rd_rst}), 32'd0);
        check({tag, "_fv"}, 32'(frame_valid), 32'd0);
    endtask

    initial begin
        int waited;
        rst_n = 1'b0; init_done = 1'b0; wr_vsync = 1'b0; rd_vsync = 1'b0;
        m_drop = 0; m_repeat = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_outputs("post_reset");

        // Events before init_done must be ignored.
        step(1, 0);
        step(0, 1);

        init_done = 1'b1;
        m_state = 1;
        repeat (2) @(negedge clk);
        step(1, 0);
        check("prime1_fv", 32'(frame_valid), 32'd0);
        step(1, 0);
        check("prime2_fv", 32'(frame_valid), 32'd0);

        // W=1, F=0, R=2 here: simultaneous events hand the reader bank 1.
        step(1, 1);
        check("both_fv", 32'(frame_valid), 32'd1);
        step(1, 0);
        step(0, 1);
        step(0, 1);
`ifdef FRAME_STAT_EN
        check("repeat_cnt", 32'(repeat_cnt), 32'(m_repeat));
`endif
        step(1, 0);
        step(1, 0);
        step(1, 0);
`ifdef FRAME_STAT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
        step(0, 1);
        check("run_fv", 32'(frame_valid), 32'd1);

        @(negedge clk);
        init_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_outputs("init_drop");
        step(1, 0);

        init_done = 1'b1;
        m_state = 1;
        repeat (2) @(negedge clk);
        step(1, 0);
        step(1, 0);
        check("reprime_fv", 32'(frame_valid), 32'd0);

        waited = 0;
        while (sb.size() != 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
